// File: rtl/switch_pkg.sv
// Shared switch-conditioning constants, used by the debouncer and the mux/LED top.
package switch_pkg;

   localparam int unsigned SW_WIDTH                = 3;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

   typedef enum logic {
      DB_IDLE  = 1'b0,
      DB_COUNT = 1'b1
   } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, hold-time debounce counter, and
// registered level plus single-cycle rise/fall pulses.
module debounce_bit
   import switch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   db_state_e        state;

   // Only sync2 is ever compared; raw is never used combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         state  <= DB_IDLE;
         stable <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         case (state)
            DB_IDLE: begin
               if (sync2 != stable) begin
                  if (cnt == CNT_LAST) begin
                     // Single-cycle hold time: accept on the first mismatch.
                     stable <= sync2;
                     rise   <= sync2;
                     fall   <= ~sync2;
                     cnt    <= '0;
                  end else begin
                     cnt   <= CNT_ONE;
                     state <= DB_COUNT;
                  end
               end
            end
            DB_COUNT: begin
               if (sync2 == stable) begin
                  cnt   <= '0;
                  state <= DB_IDLE;
               end else if (cnt == CNT_LAST) begin
                  stable <= sync2;
                  rise   <= sync2;
                  fall   <= ~sync2;
                  cnt    <= '0;
                  state  <= DB_IDLE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               cnt   <= '0;
               state <= DB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/switch_debounce.sv
// Conditions the raw slide switches: one debouncer per bit, plus a combined
// change strobe for downstream logic.
module switch_debounce
   import switch_pkg::*;
#(
   parameter int unsigned WIDTH           = SW_WIDTH,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce_bit (
         .clk    (clk),
         .rst_n  (rst_n),
         .raw    (sw_raw[i]),
         .stable (sw_stable[i]),
         .rise   (sw_rise[i]),
         .fall   (sw_fall[i])
      );
   end

   // Pulses are already registered, so this OR lines up with them exactly.
   assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_switch_debounce.sv
// Directed plus randomized bench for switch_debounce against a sample-history model.
module tb_switch_debounce;

   localparam int unsigned W = 3;
   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] sw_raw = '0;
   logic [W-1:0] sw_stable;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         sw_changed;

   int total = 0;
   int bad   = 0;

   // Model: raw passes through two sample stages; a bit's level flips once the
   // last N synchronised samples all disagree with the current level.
   logic [W-1:0] m_s1, m_s2, m_stable, m_rise, m_fall;
   logic [W-1:0] m_hist[$];

   switch_debounce #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (N)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_raw     (sw_raw),
      .sw_stable  (sw_stable),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sw_changed (sw_changed)
   );

   always #5 clk = ~clk;

   function automatic logic led_of(input logic [W-1:0] s);
      return s[0] ? s[1] : s[2];
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
      m_hist.delete();
   endtask

   task automatic model_edge(input logic [W-1:0] raw);
      if (!rst_n) begin
         m_reset();
      end else begin
         m_hist.push_back(m_s2);
         if (m_hist.size() > N) void'(m_hist.pop_front());
         m_rise = '0;
         m_fall = '0;
         if (m_hist.size() == N) begin
            for (int b = 0; b < int'(W); b++) begin
               bit all_diff = 1'b1;
               foreach (m_hist[j]) if (m_hist[j][b] == m_stable[b]) all_diff = 1'b0;
               if (all_diff) begin
                  m_stable[b] = ~m_stable[b];
                  if (m_stable[b]) m_rise[b] = 1'b1;
                  else             m_fall[b] = 1'b1;
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = raw;
      end
   endtask

   task automatic cyc(input logic [W-1:0] raw);
      sw_raw = raw;
      @(posedge clk);
      model_edge(raw);
      #1;
      chk("stable", sw_stable, m_stable);
      chk("rise",   sw_rise,   m_rise);
      chk("fall",   sw_fall,   m_fall);
      chk("changed", W'(sw_changed), W'(|(m_rise | m_fall)));
   endtask

   task automatic run_hold(input logic [W-1:0] raw, input int n, output int first_k,
                           output int n_chg, output logic [W-1:0] rise_at,
                           output logic [W-1:0] fall_at);
      first_k = -1; n_chg = 0; rise_at = '0; fall_at = '0;
      for (int k = 0; k < n; k++) begin
         cyc(raw);
         if (sw_changed === 1'b1) begin
            n_chg++;
            if (first_k < 0) begin
               first_k = k; rise_at = sw_rise; fall_at = sw_fall;
            end
         end
      end
   endtask

   initial begin
      int           k, n;
      logic [W-1:0] r, f;
      m_reset();

      // Reset held with switches high: everything stays 0.
      sw_raw = 3'b111;
      #1;
      chk("async_reset_stable", sw_stable, 3'b000);
      for (int i = 0; i < 3; i++) cyc(3'b111);
      rst_n = 1'b1;
      run_hold(3'b111, 10, k, n, r, f);
      chk_int("reset_release_latency", k, 5);
      chk_int("reset_release_pulses", n, 1);
      chk("reset_release_rise", r, 3'b111);

      // All low, then bit0 bounces before settling high.
      run_hold(3'b000, 10, k, n, r, f);
      chk("all_fall", f, 3'b111);
      run_hold(3'b001, 2, k, n, r, f);
      chk_int("bounce_a_quiet", n, 0);
      run_hold(3'b000, 2, k, n, r, f);
      chk_int("bounce_b_quiet", n, 0);
      run_hold(3'b001, 10, k, n, r, f);
      chk_int("bounce_latency", k, 5);
      chk_int("bounce_pulses", n, 1);
      chk("bounce_rise", r, 3'b001);

      // Three-cycle glitch on bit1 is filtered out.
      run_hold(3'b011, 3, k, n, r, f);
      chk_int("glitch_a_quiet", n, 0);
      run_hold(3'b001, 10, k, n, r, f);
      chk_int("glitch_b_quiet", n, 0);
      chk("glitch_stable", sw_stable, 3'b001);

      // Fall from 010.
      run_hold(3'b010, 12, k, n, r, f);
      chk("pre_fall_stable", sw_stable, 3'b010);
      run_hold(3'b000, 10, k, n, r, f);
      chk_int("fall_latency", k, 5);
      chk_int("fall_pulses", n, 1);
      chk("fall_vec", f, 3'b010);
      chk("fall_no_rise", r, 3'b000);

      // Mux integration: led = sw[0] ? sw[1] : sw[2].
      run_hold(3'b011, 10, k, n, r, f);
      chk("led_high", W'(led_of(sw_stable)), W'(led_of(m_stable)));
      chk("led_high_abs", W'(led_of(sw_stable)), 3'b001);
      run_hold(3'b010, 10, k, n, r, f);
      chk("led_low_abs", W'(led_of(sw_stable)), 3'b000);

      // Mid-count reset while bit2 is being qualified.
      run_hold(3'b110, 4, k, n, r, f);
      chk_int("midcount_quiet", n, 0);
      rst_n = 1'b0;
      m_reset();
      #2;
      chk("midcount_reset_stable", sw_stable, 3'b000);
      rst_n = 1'b1;
      run_hold(3'b110, 10, k, n, r, f);
      chk_int("midcount_latency", k, 5);
      chk_int("midcount_pulses", n, 1);
      chk("midcount_rise", r, 3'b110);

      // Randomized segments with occasional resets.
      for (int s = 0; s < 60; s++) begin
         logic [W-1:0] rv;
         int           len;
         rv  = W'($urandom);
         len = int'($urandom_range(1, 8));
         for (int c = 0; c < len; c++) cyc(rv);
         if ($urandom_range(0, 14) == 0) begin
            rst_n = 1'b0;
            m_reset();
            #2;
            chk("rand_reset_stable", sw_stable, 3'b000);
            rst_n = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
